compressor_tree_pipe: RTL and testbench
=======================================

Name: compressor_tree_pipe

Overview:
Parametrised, pipelined multi-operand carry-save reducer built from 3:2 compressor rows. It reduces NUM_IN operands of WIDTH bits to a redundant sum/carry pair of OUT_W bits. Pipeline registers sit between reduction levels and carry a valid/ready handshake with backpressure. Used in the modular-square datapath in place of fixed-shape combinational compressor arrays.

Parameters:
NUM_IN, 12, number of input operands; legal range 2..64.
WIDTH, 16, bits per input operand.
REG_EVERY, 1, number of 3:2 levels between pipeline register banks; legal range >=1.
OUT_W, WIDTH+clog2(NUM_IN), output width; a value below the default is illegal (elaboration error).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-high.
clr  in  1  synchronous flush; drops all in-flight valids.
in_valid  in  1  operand set valid.
in_ready  out  1  block accepts the set this cycle.
in_data  in  NUM_IN*WIDTH  operand i occupies [i*WIDTH +: WIDTH].
out_valid  out  1  sum/carry pair valid.
out_ready  in  1  downstream accepts.
out_sum  out  OUT_W  redundant sum word.
out_carry  out  OUT_W  redundant carry word, already weight-aligned (shifted left 1).

Behaviour:
- Reset (async, rst=1): every stage valid = 0 and every stage data register = 0; out_valid=0, out_sum=0, out_carry=0. in_ready=1 in the first cycle after release.
- Operands are zero-extended to OUT_W before reduction.
- Per level, operand count n maps to 2*floor(n/3) + (n mod 3). Each complete triple is fed to one 3:2 row: sum = a^b^c; carry = maj(a,b,c) shifted left 1, truncated to OUT_W. Leftover operands pass through unchanged. Levels repeat until n<=2. LEVELS = number of levels; for 12 operands the chain is 12->8->6->4->3->2, so LEVELS=5.
- NUM_IN=2 gives LEVELS=0: the operands pass straight through to the single register bank.
- NUM_REG = max(1, ceil(LEVELS/REG_EVERY)) register banks. The last bank drives the outputs directly, so there is no combinational path from in_data to out_*.
- Latency = NUM_REG cycles from an accepted input to out_valid, when there are no stalls. For NUM_IN=12 and REG_EVERY=1 this is 5.
- Invariant: (out_sum + out_carry) mod 2^OUT_W equals the exact sum of the NUM_IN operands. The default OUT_W makes this sum exact.
- Handshake, with banks k=0..NUM_REG-1:
  - adv_k = ~v_k | adv_{k+1}; adv_{NUM_REG} = out_ready.
  - in_ready = adv_0, so it is combinational from out_ready through the ready chain.
  - Bank k loads when adv_k=1. Its new valid is the upstream valid (in_valid for k=0).
  - Data in a bank loads only when the upstream valid is 1; otherwise the data holds.
- Bubbles collapse: with out_ready=0, the pipeline fills to NUM_REG entries and only then lowers in_ready. Nothing is dropped or duplicated.
- out_sum, out_carry and out_valid are held stable while out_valid=1 and out_ready=0.
- clr=1: all v_k <= 0 on the next edge and in_ready is forced 0 in that cycle. Data registers are not cleared. clr takes priority over a simultaneous accept.
- rst asserted mid-transfer: everything in flight is lost and outputs return to reset values asynchronously.

Decomposition:
- Shared package (compressor_pkg):
  - function csa_levels(n), returning LEVELS.
  - function csa_count(n, lvl), returning the operand count at a given level.
  - function out_width(num_in, width).
- Sub-module csa_row (parameter W): vector 3:2 row built from the existing compressor_3_2 per bit. It outputs sum[W] and carry[W] with the carry pre-shifted.
- The generate loop for levels and banks stays in compressor_tree_pipe.

Test Plan:
- NUM_IN=12, WIDTH=16: all operands 0xFFFF, out_ready=1 -> after 5 cycles out_valid=1 and out_sum+out_carry mod 2^20 = 786420 (0xBFFF4).
- Operands i+1 (1..12), one beat per cycle for 20 beats, out_ready=1 -> each output sums to 78. Outputs arrive back-to-back, in_ready stays 1 throughout, latency is 5.
- out_ready=0 with in_valid held -> exactly 5 sets accepted, then in_ready=0. Raise out_ready -> the 5 results drain in order, and in_ready=1 in that same cycle.
- NUM_IN=2, WIDTH=8, operands 0xFF and 0x01 -> latency 1; out_sum+out_carry = 0x100 in OUT_W=9.
- clr asserted in a cycle with 3 sets in flight and in_valid=1 -> no out_valid appears for those sets or for the concurrent input; the next set is accepted normally with latency 5.
- rst pulsed asynchronously mid-stream -> out_valid=0 and out_sum=out_carry=0 immediately; after release, random sums match a reference model over 10k beats with random out_ready.

Source files
------------

// File: rtl/compressor_pkg.sv
// compressor_pkg: shape helpers for the pipelined carry-save reduction tree
package compressor_pkg;
  function automatic int csa_step(int n);
    return 2 * (n / 3) + n % 3;
  endfunction
  function automatic int csa_count(int n, int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = csa_step(c);
    return c;
  endfunction
  function automatic int csa_levels(int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = csa_step(c);
      l++;
    end
    return l;
  endfunction
  function automatic int out_width(int num_in, int width);
    return width + $clog2(num_in);
  endfunction
  function automatic int num_banks(int levels, int reg_every);
    return levels == 0 ? 1 : (levels + reg_every - 1) / reg_every;
  endfunction
endpackage

// File: rtl/compressor_3_2.sv
// compressor_3_2: single-bit full-adder style 3:2 compressor
module compressor_3_2 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/compressor_tree_pipe_csa_row.sv
// csa_row: W-bit 3:2 row; carry leaves already shifted to its weight and truncated to W
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  logic [W-1:0] cy;
  for (genvar i = 0; i < W; i++) begin : g_bit
    compressor_3_2 u_fa (.a(a[i]), .b(b[i]), .c(c[i]), .s(sum[i]), .co(cy[i]));
  end
  assign carry = W'({cy, 1'b0});
endmodule

// File: rtl/compressor_tree_pipe.sv
// compressor_tree_pipe: pipelined 3:2 carry-save reducer with valid/ready register banks
module compressor_tree_pipe
  import compressor_pkg::*;
#(
  parameter int NUM_IN    = 12,
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 1,
  parameter int OUT_W     = out_width(NUM_IN, WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_sum,
  output logic [OUT_W-1:0]        out_carry
);
  localparam int LEVELS  = csa_levels(NUM_IN);
  localparam int NUM_REG = num_banks(LEVELS, REG_EVERY);
  if (NUM_IN < 2 || NUM_IN > 64 || REG_EVERY < 1 || OUT_W < out_width(NUM_IN, WIDTH)) begin : g_bad
    $error("compressor_tree_pipe: illegal parameters");
  end
  logic [OUT_W-1:0] d [LEVELS+1][NUM_IN];
  logic [OUT_W-1:0] q [NUM_REG][NUM_IN];
  logic [NUM_REG:0] vin;
  logic [NUM_REG:0] adv;
  assign vin[0] = in_valid;
  assign adv[NUM_REG] = out_ready;
  assign in_ready = adv[0] & ~clr;
  assign out_valid = vin[NUM_REG];
  assign out_sum = q[NUM_REG-1][0];
  assign out_carry = q[NUM_REG-1][1];
  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign d[0][i] = OUT_W'(in_data[i*WIDTH +: WIDTH]);
  end
  // Level l reads the bank register when a bank boundary sits just before it
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N = csa_count(NUM_IN, l);
    localparam int T = N / 3;
    logic [OUT_W-1:0] x [NUM_IN];
    if (l > 0 && l % REG_EVERY == 0) begin : g_q
      assign x = q[l/REG_EVERY-1];
    end else begin : g_d
      assign x = d[l];
    end
    for (genvar j = 0; j < T; j++) begin : g_row
      csa_row #(.W(OUT_W)) u_row (
        .a(x[3*j]), .b(x[3*j+1]), .c(x[3*j+2]),
        .sum(d[l+1][2*j]), .carry(d[l+1][2*j+1])
      );
    end
    for (genvar i = 2 * T; i < NUM_IN; i++) begin : g_pass
      if (i < N - T) begin : g_use
        assign d[l+1][i] = x[i+T];
      end else begin : g_zero
        assign d[l+1][i] = '0;
      end
    end
  end
  for (genvar k = 0; k < NUM_REG; k++) begin : g_bank
    localparam int B = (k + 1) * REG_EVERY < LEVELS ? (k + 1) * REG_EVERY : LEVELS;
    logic vr;
    logic [OUT_W-1:0] qr [NUM_IN];
    assign vin[k+1] = vr;
    assign q[k] = qr;
    assign adv[k] = ~vr | adv[k+1];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        vr <= 1'b0;
        for (int i = 0; i < NUM_IN; i++) qr[i] <= '0;
      end else begin
        vr <= clr ? 1'b0 : adv[k] ? vin[k] : vr;
        if (adv[k] && vin[k]) qr <= d[B];
      end
  end
endmodule

// File: tb/tb_compressor_tree_pipe.sv
// tb_compressor_tree_pipe: scoreboard bench for the 12x16 tree plus a 2x8 pass-through instance
module tb_compressor_tree_pipe;
  typedef struct {
    logic [19:0] s;
    int          c;
  } ent_t;
  logic         clk = 0;
  logic         rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic [191:0] in_data;
  logic [19:0]  out_sum, out_carry;
  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [15:0]  s_in_data;
  logic [8:0]   s_out_sum, s_out_carry;
  ent_t         sb[$];
  ent_t         e;
  int           checks = 0, passes = 0, cyc = 0, n, acc;
  logic         lat_chk = 0, hold = 0, seen;
  logic [19:0]  ps, pc;

  compressor_tree_pipe dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry)
  );
  compressor_tree_pipe #(.NUM_IN(2), .WIDTH(8)) dut_s (
    .clk(clk), .rst(rst), .clr(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_carry(s_out_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] ref_sum(logic [191:0] dv);
    logic [19:0] s;
    s = '0;
    for (int i = 0; i < 12; i++) s += 20'(dv[i*16 +: 16]);
    return s;
  endfunction

  // Handshakes are judged at the falling edge, ahead of the rising edge that commits them
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", out_sum, ps);
        chk("hold_carry", out_carry, pc);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sum", 20'(out_sum + out_carry), e.s);
          if (lat_chk) chk("latency", cyc - e.c, 5);
        end
      end
      if (in_valid && in_ready) sb.push_back('{ref_sum(in_data), cyc});
      if (clr) sb.delete();
      hold = out_valid && !out_ready && !clr;
      ps = out_sum;
      pc = out_carry;
    end
  end

  initial begin
    rst = 1; clr = 0; in_valid = 0; in_data = '0; out_ready = 1;
    s_in_valid = 0; s_in_data = '0; s_out_ready = 1;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_carry", out_carry, 0);
    chk("rst_s_valid", s_out_valid, 0);
    #20 rst = 0;
    step;
    chk("ready_after_rst", in_ready, 1);
    lat_chk = 1;
    in_data = {12{16'hFFFF}};
    in_valid = 1;
    step;
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 20) begin
      step;
      n++;
    end
    chk("lat_ffff", n, 5);
    chk("sum_ffff", 20'(out_sum + out_carry), 20'hBFFF4);
    repeat (3) step;
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 12; i++) in_data[i*16 +: 16] = 16'(i + 1);
      in_valid = 1;
      chk("ready_stream", in_ready, 1);
      step;
    end
    in_valid = 0;
    repeat (8) step;
    lat_chk = 0;
    out_ready = 0;
    acc = 0;
    in_valid = 1;
    for (int b = 1; b <= 10; b++) begin
      if (in_ready) acc++;
      if (in_ready) in_data = {12{16'(acc)}};
      step;
    end
    chk("stall_accepts", acc, 5);
    chk("stall_ready", in_ready, 0);
    in_valid = 0;
    out_ready = 1;
    #1;
    chk("ready_on_release", in_ready, 1);
    repeat (8) step;
    lat_chk = 1;
    for (int b = 0; b < 3; b++) begin
      in_data = {12{16'(100 + b)}};
      in_valid = 1;
      step;
    end
    clr = 1;
    in_data = {12{16'd7}};
    #1;
    chk("ready_clr", in_ready, 0);
    step;
    clr = 0;
    in_valid = 0;
    seen = 0;
    repeat (8) begin
      if (out_valid) seen = 1;
      step;
    end
    chk("clr_no_valid", seen, 0);
    in_data = {12{16'h1234}};
    in_valid = 1;
    step;
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 20) begin
      step;
      n++;
    end
    chk("lat_after_clr", n, 5);
    chk("sum_after_clr", 20'(out_sum + out_carry), 20'h0DA70);
    step;
    chk("s_idle", s_out_valid, 0);
    s_in_data = {8'h01, 8'hFF};
    s_in_valid = 1;
    step;
    s_in_valid = 0;
    chk("s_valid", s_out_valid, 1);
    chk("s_sum", 9'(s_out_sum + s_out_carry), 9'h100);
    out_ready = 1;
    in_valid = 1;
    repeat (8) begin
      for (int i = 0; i < 12; i++) in_data[i*16 +: 16] = 16'($urandom);
      step;
    end
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_carry", out_carry, 0);
    in_valid = 0;
    #10 rst = 0;
    step;
    lat_chk = 0;
    for (int b = 0; b < 10000; b++) begin
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(2) != 0;
      for (int i = 0; i < 12; i++) in_data[i*16 +: 16] = 16'($urandom);
      step;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (10) step;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
